// File: rtl/data_path.sv
// UART-attached 8-bit MIPS-style ALU: receives opcode/A/B bytes over 8N1 serial,
// executes one operation and returns the result as a single serial byte.
module data_path #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [2:0] SQ_GET_OP = 3'd0;
  localparam logic [2:0] SQ_GET_A  = 3'd1;
  localparam logic [2:0] SQ_GET_B  = 3'd2;
  localparam logic [2:0] SQ_EXEC   = 3'd3;
  localparam logic [2:0] SQ_SEND   = 3'd4;

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = ~(a | b);
      4'd6:    alu_f = (sa < sb) ? 8'h01 : 8'h00;
      4'd7:    alu_f = a << b[2:0];
      4'd8:    alu_f = a >> b[2:0];
      4'd9:    alu_f = sa >>> b[2:0];
      default: alu_f = 8'hFF;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous rx pin
  logic r_rx_p0 = 1'b1;
  logic r_rx_p1 = 1'b1;
  logic w_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_p0 <= 1'b1;
      r_rx_p1 <= 1'b1;
    end else begin
      r_rx_p0 <= rx;
      r_rx_p1 <= r_rx_p0;
    end
  end

  assign w_rx = r_rx_p1;

  // Receiver: mid-bit sampling, framing errors park in WAIT_HIGH until the line recovers
  logic [2:0]        r_rx_state = RX_IDLE;
  logic [CNT_W-1:0]  r_rx_cnt   = '0;
  logic [2:0]        r_rx_bit   = '0;
  logic [DATA_W-1:0] r_rx_sh    = '0;
  logic [DATA_W-1:0] r_rx_byte  = '0;
  logic              r_byte_vld = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!w_rx) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {w_rx, r_rx_sh[DATA_W-1:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt <= '0;
            if (w_rx) begin
              r_rx_byte  <= r_rx_sh;
              r_byte_vld <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: if (w_rx) r_rx_state <= RX_IDLE;
        default:      r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sequencer + transmitter: r_tx_bit 0 = start, 1..8 = data, 9 = stop
  logic [2:0]        r_sq_state = SQ_GET_OP;
  logic [3:0]        r_op       = '0;
  logic [DATA_W-1:0] r_a        = '0;
  logic [DATA_W-1:0] r_b        = '0;
  logic [DATA_W-1:0] r_tx_sh    = '0;
  logic [CNT_W-1:0]  r_tx_cnt   = '0;
  logic [3:0]        r_tx_bit   = '0;
  logic              r_tx       = 1'b1;
  logic [DATA_W-1:0] w_alu;

  assign w_alu = alu_f(r_op, r_a, r_b);
  assign tx    = r_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sq_state <= SQ_GET_OP;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_tx_sh    <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_sq_state)
        SQ_GET_OP: if (r_byte_vld) begin
          r_op       <= r_rx_byte[3:0];
          r_sq_state <= SQ_GET_A;
        end
        SQ_GET_A: if (r_byte_vld) begin
          r_a        <= r_rx_byte;
          r_sq_state <= SQ_GET_B;
        end
        SQ_GET_B: if (r_byte_vld) begin
          r_b        <= r_rx_byte;
          r_sq_state <= SQ_EXEC;
        end
        SQ_EXEC: begin
          r_tx_sh    <= w_alu;
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx       <= 1'b0;
          r_sq_state <= SQ_SEND;
        end
        SQ_SEND: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
              r_tx       <= 1'b1;
              r_sq_state <= SQ_GET_OP;
            end else begin
              r_tx_bit <= r_tx_bit + 4'd1;
              if (r_tx_bit == 4'd8) begin
                r_tx <= 1'b1;
              end else begin
                r_tx    <= r_tx_sh[0];
                r_tx_sh <= {1'b0, r_tx_sh[DATA_W-1:1]};
              end
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_sq_state <= SQ_GET_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: serial commands in, decoded serial results
// popped against expected bytes queued at stimulus time.
module tb_data_path;

  localparam int CPB     = 16;
  localparam int LAT_MIN = 9 * CPB + CPB / 2;
  localparam int LAT_MAX = LAT_MIN + 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  data_path #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .tx    (tx)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp    = 0;
  int         n_mis    = 0;
  int         n_extra  = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int         t_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame decoder on tx, sampled at mid-bit on falling clock edges
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        int         t0;
        int         d;
        logic [7:0] got;
        t0       = cyc;
        mon_busy = 1'b1;
        repeat (CPB / 2 - 1) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_extra++;
          $display("Unexpected frame 0x%0h at cycle %0d", got, t0);
        end else begin
          chk("result_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
          if (t_q.size() > 0) begin
            d = t0 - t_q.pop_front();
            chk("start_latency_in_window", {31'd0, (d >= LAT_MIN && d <= LAT_MAX)}, 32'd1);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rec);
    @(negedge clk);
    rx = 1'b0;
    if (rec) t_q.push_back(cyc);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !mon_busy) break;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
    exp_q.push_back(exp);
    send_byte(op, 1'b0);
    send_byte(a, 1'b0);
    send_byte(b, 1'b1);
    drain();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up with no reset: line must stay idle
    for (int i = 0; i < 20; i++) begin
      repeat (100) @(negedge clk);
      chk("powerup_tx_idle", {31'd0, tx}, 32'd1);
    end

    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("reset_tx_idle", {31'd0, tx}, 32'd1);

    send_cmd(8'h00, 8'h05, 8'h03, 8'h08);
    send_cmd(8'h01, 8'h03, 8'h05, 8'hFE);
    send_cmd(8'h06, 8'hFF, 8'h01, 8'h01);
    send_cmd(8'h09, 8'h80, 8'h03, 8'hF0);
    send_cmd(8'h0C, 8'h12, 8'h34, 8'hFF);
    send_cmd(8'h05, 8'h0F, 8'hF0, 8'h00);
    send_cmd(8'h07, 8'h81, 8'h03, 8'h08);
    send_cmd(8'h08, 8'h81, 8'h0B, 8'h10);
    send_cmd(8'hF6, 8'h01, 8'hFF, 8'h00);
    send_cmd(8'h04, 8'hAA, 8'hFF, 8'h55);

    // Break: line held low, then released
    @(negedge clk) rx = 1'b0;
    repeat (500) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    chk("break_no_frame", n_extra, 32'd0);
    chk("break_tx_idle", {31'd0, tx}, 32'd1);
    send_cmd(8'h03, 8'hA0, 8'h05, 8'hA5);

    // Partial command aborted by reset
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    send_cmd(8'h04, 8'h0F, 8'hF0, 8'hFF);

    // Short low glitch while idle
    @(negedge clk) rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    send_cmd(8'h02, 8'hF0, 8'h3C, 8'h30);

    repeat (400) @(negedge clk);
    chk("unexpected_frames", n_extra, 32'd0);
    chk("final_tx_idle", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
